// File: rtl/pes_pump_zone_scheduler.sv
// Multi-zone irrigation scheduler: per-zone sensor debounce, round-robin pump sharing,
// bounded watering bursts with soak time, and retry-based fault isolation.
module pes_pump_zone_scheduler #(
    parameter int NZONES       = 4,
    parameter int DEBOUNCE     = 4,
    parameter int WATER_CYCLES = 16,
    parameter int SOAK_CYCLES  = 8,
    parameter int MAX_RETRIES  = 3
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      enable,
    input  logic [NZONES-1:0]         moisture_sensor,
    input  logic [NZONES-1:0]         fault_clr,
    output logic                      water_pump,
    output logic [NZONES-1:0]         valve,
    output logic [$clog2(NZONES)-1:0] zone_id,
    output logic                      busy,
    output logic [NZONES-1:0]         fault
);
    localparam int ZW  = $clog2(NZONES);
    localparam int DBW = $clog2(DEBOUNCE + 1);
    localparam int WCW = $clog2(WATER_CYCLES + 1);
    localparam int SCW = $clog2(SOAK_CYCLES + 1);
    localparam int RTW = $clog2(MAX_RETRIES + 1);

    typedef enum logic [2:0] {IDLE, OPEN, PUMP, CLOSE, SOAK} state_t;
    state_t state;

    logic [NZONES-1:0] sync1, sync2, dry_sync, dry_db, req;
    logic [DBW-1:0]    db_cnt [NZONES];
    logic [RTW-1:0]    retry  [NZONES];
    logic [WCW-1:0]    burst_cnt;
    logic [SCW-1:0]    soak_cnt;
    logic [ZW-1:0]     rr_ptr, grant_idx, next_ptr;
    logic              grant_found;

    assign dry_sync = ~sync2;
    assign req      = dry_db & ~fault & {NZONES{enable}};
    assign next_ptr = (zone_id == ZW'(NZONES - 1)) ? '0 : zone_id + ZW'(1);

    // Synchronizers reset to the wet level so a dry sensor needs the full debounce after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1  <= '1;
            sync2  <= '1;
            dry_db <= '0;
            for (int i = 0; i < NZONES; i++) db_cnt[i] <= '0;
        end else begin
            sync1 <= moisture_sensor;
            sync2 <= sync1;
            for (int i = 0; i < NZONES; i++) begin
                if (dry_sync[i] != dry_db[i]) begin
                    if (db_cnt[i] == DBW'(DEBOUNCE - 1)) begin
                        dry_db[i] <= dry_sync[i];
                        db_cnt[i] <= '0;
                    end else begin
                        db_cnt[i] <= db_cnt[i] + DBW'(1);
                    end
                end else begin
                    db_cnt[i] <= '0;
                end
            end
        end
    end

    // Descending scan so the requester closest to rr_ptr is the one left standing.
    always_comb begin
        int idx;
        idx         = 0;
        grant_found = 1'b0;
        grant_idx   = '0;
        for (int k = NZONES - 1; k >= 0; k--) begin
            idx = (int'(rr_ptr) + k) % NZONES;
            if (req[idx]) begin
                grant_found = 1'b1;
                grant_idx   = ZW'(idx);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            water_pump <= 1'b0;
            valve      <= '0;
            zone_id    <= '0;
            busy       <= 1'b0;
            fault      <= '0;
            rr_ptr     <= '0;
            burst_cnt  <= '0;
            soak_cnt   <= '0;
            for (int i = 0; i < NZONES; i++) retry[i] <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (grant_found) begin
                        state   <= OPEN;
                        zone_id <= grant_idx;
                        valve   <= NZONES'(1) << grant_idx;
                        busy    <= 1'b1;
                    end
                end
                OPEN: begin
                    state      <= PUMP;
                    water_pump <= 1'b1;
                    burst_cnt  <= '0;
                end
                PUMP: begin
                    if (!enable || !dry_db[zone_id] || burst_cnt == WCW'(WATER_CYCLES - 1)) begin
                        state      <= CLOSE;
                        water_pump <= 1'b0;
                        rr_ptr     <= next_ptr;
                        if (enable && !dry_db[zone_id]) begin
                            retry[zone_id] <= '0;
                        end else if (enable) begin
                            if (retry[zone_id] == RTW'(MAX_RETRIES - 1)) begin
                                fault[zone_id] <= 1'b1;
                                retry[zone_id] <= '0;
                            end else begin
                                retry[zone_id] <= retry[zone_id] + RTW'(1);
                            end
                        end
                    end else begin
                        burst_cnt <= burst_cnt + WCW'(1);
                    end
                end
                CLOSE: begin
                    state    <= SOAK;
                    valve    <= '0;
                    soak_cnt <= '0;
                end
                SOAK: begin
                    if (soak_cnt == SCW'(SOAK_CYCLES - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        soak_cnt <= soak_cnt + SCW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
            // Placed last so a clear overrides a fault being set on the same edge.
            for (int i = 0; i < NZONES; i++) begin
                if (fault_clr[i]) begin
                    fault[i] <= 1'b0;
                    retry[i] <= '0;
                end
            end
        end
    end
endmodule

// File: doc/pes_pump_zone_scheduler.md
# pes_pump_zone_scheduler

Multi-zone irrigation scheduler that shares one water pump among NZONES plant zones, each with its own moisture sensor and valve. Sits above the single-zone pump control path. Debounces each sensor, arbitrates dry zones round-robin, sequences valve/pump on and off, and enforces a bounded watering burst plus soak time. Zones that stay dry after repeated full bursts are flagged faulty and removed from arbitration.

## Interface
- NZONES, 4, number of zones (2..8)
- DEBOUNCE, 4, cycles a synchronized sensor level must hold before the debounced state changes
- WATER_CYCLES, 16, maximum pump-on cycles per burst
- SOAK_CYCLES, 8, idle cycles after each burst with all valves closed
- MAX_RETRIES, 3, consecutive timed-out bursts before a zone faults
- clk  in  1  single clock, rising edge
- rst  in  1  synchronous, active-high reset
- enable  in  1  scheduler enable; 0 blocks new bursts and aborts an active one
- moisture_sensor  in  NZONES  raw per-zone sensor, asynchronous; 1 = wet, 0 = dry
- fault_clr  in  NZONES  per-zone single-cycle pulse, clears fault and retry count
- water_pump  out  1  shared pump drive
- valve  out  NZONES  per-zone valve, one-hot or zero
- zone_id  out  $clog2(NZONES)  zone currently or last served
- busy  out  1  high in every state except IDLE
- fault  out  NZONES  sticky per-zone fault flags

## Operation
- Per zone: 2-flop synchronizer, then debounce counter; dry_db[i] takes the new level on the edge where the synchronized level has differed from dry_db[i] for DEBOUNCE consecutive cycles. Any bounce restarts the count.
- req[i] = dry_db[i] & ~fault[i] & enable.
- Arbitration, IDLE only: grant the first requesting zone at or after rr_ptr, wrapping modulo NZONES. rr_ptr resets to 0 and is set to (granted+1) mod NZONES on entry to CLOSE.
- States:
  - IDLE: no request → IDLE; request → OPEN, with zone_id and valve[zone] set.
  - OPEN: 1 cycle; valve on, pump off → PUMP.
  - PUMP: pump on, burst counter increments each cycle.
    - dry_db[zone]=0 (wet): → CLOSE, retry[zone] cleared.
    - Counter reaches WATER_CYCLES: → CLOSE, retry[zone]+1. If this reaches MAX_RETRIES, fault[zone] set and retry[zone] cleared.
    - enable=0: → CLOSE, retry unchanged. Takes priority over both exits above on the same cycle.
    - Wet and timeout on the same cycle: the wet exit wins.
  - CLOSE: 1 cycle; pump off, valve held on → SOAK.
  - SOAK: all valves off for SOAK_CYCLES cycles → IDLE.
- Invariants:
  - water_pump=1 only while exactly one valve bit is 1.
  - A valve changes only while water_pump=0.
  - zone_id holds its value through IDLE.
- fault_clr[i] clears fault[i] and retry[i]; it takes priority over a fault set on the same edge. Asserting fault_clr for the active zone has no effect on the burst in progress.
- Sensor changes on non-active zones during a burst only update their dry_db.

## Timing
- Reset values: water_pump=0, valve=0, zone_id=0, busy=0, fault=0, all retry counts 0, rr_ptr=0, all dry_db=0, state IDLE.
- Reset mid-burst drops the pump and valves on the reset edge itself.
- Sensor to dry_db: DEBOUNCE+2 cycles, for a stable raw change.
- dry_db rise at edge e, with zone idle and enabled: valve rises at e+1, water_pump at e+2.
- Timed-out burst: water_pump high exactly WATER_CYCLES cycles.
- Wet exit: pump falls on the edge after dry_db falls.
- Valve falls 1 cycle after pump; next grant no earlier than SOAK_CYCLES+1 cycles after the valve falls.
- Full timed-out service period for one zone: 1 (OPEN) + WATER_CYCLES + 1 (CLOSE) + SOAK_CYCLES + 1 (IDLE) = 27 cycles at defaults.
- busy asserted from the OPEN entry edge through the last SOAK cycle.

## Test plan
All scenarios use default parameters.
- Single-zone wet exit: release rst, enable=1, moisture_sensor=4'b1110 → valve=4'b0001 after 7 cycles and pump after 8. Set sensor[0]=1 after 5 pump cycles → pump falls 7 cycles later, valve 1 cycle after that, retry[0]=0.
- Round-robin: hold sensor=4'b0000 → grant order 0,1,2,3,0. Each burst is 16 pump cycles. Exactly one valve bit set at any time, and never a valve change while the pump is on.
- Fault: hold sensor[2]=0, others wet → three consecutive 16-cycle bursts on zone 2, fault=4'b0100 at the third CLOSE, no further grants. A fault_clr[2] pulse then causes a new grant after the next IDLE cycle.
- Debounce: toggle sensor[1] 0/1 every 2 cycles for 40 cycles → dry_db[1] never changes, valve stays 0, busy stays 0.
- Abort: drop enable on pump cycle 6 → pump 0 on the next edge, valve 0 one cycle later, then SOAK, retry unchanged. No grants while enable=0.
- Reset mid-PUMP: assert rst for 1 cycle → on that edge water_pump=0, valve=0, fault=0, busy=0, zone_id=0. After release, the first grant goes to zone 0.
